// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM bus arbiter.
// The arbitration policy is selected by RAM_ARB_ROUND_ROBIN_EN (see rr_arb2).
package ram_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 8;

    // Inactive level of the active-low RAM strobes.
    localparam logic STROBE_OFF = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input grant logic for the RAM bus arbiter.
// RAM_ARB_ROUND_ROBIN_EN defined: round-robin with a last-grant history flop.
// RAM_ARB_ROUND_ROBIN_EN undefined: fixed priority, port 0 always wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rstb,
    input  logic [1:0] req,
    input  logic       take,
    output logic       win_c
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic last_q;

    // Winner index: a lone requester wins, a tie goes to the port not granted last.
    always_comb begin
        win_c = 1'b0;
        unique case (req)
            2'b01:   win_c = 1'b0;
            2'b10:   win_c = 1'b1;
            2'b11:   win_c = ~last_q;
            default: win_c = 1'b0;
        endcase
    end

    // History records the port of every accepted grant; reset favours port 0 next.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            last_q <= 1'b1;
        end else if (take) begin
            last_q <= win_c;
        end
    end
`else
    logic unused_c;

    // Port 1 wins only when port 0 is not requesting.
    always_comb begin
        win_c = req[1] & ~req[0];
    end

    assign unused_c = &{1'b0, clk, rstb, take};
`endif

endmodule

// File: rtl/ram_bus_arbiter.sv
// Two-port sequencer/arbiter driving a 16x8 asynchronous RAM.
// Every transaction runs IDLE->SETUP->STROBE->HOLD; WEb and OEb are never low together.
// Arbitration policy selected by RAM_ARB_ROUND_ROBIN_EN inside rr_arb2.
module ram_bus_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              ram_CEb,
    output logic              ram_WEb,
    output logic              ram_OEb
);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    state_t state_q, state_d;
    txn_t   txn_q, txn_d;
    logic   grant_q, grant_d;
    logic   win_c, take_c;
    logic   drive_q, ce_b_q, we_b_q, oe_b_q;
    logic   ack0_q, ack1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    rr_arb2 u_arb (
        .clk   (clk),
        .rstb  (rstb),
        .req   ({req1, req0}),
        .take  (take_c),
        .win_c (win_c)
    );

    // Next state; in IDLE the winner's fields are captured for the whole transaction.
    always_comb begin
        state_d = state_q;
        txn_d   = txn_q;
        grant_d = grant_q;
        take_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = SETUP;
                    take_c  = 1'b1;
                    grant_d = win_c;
                    txn_d   = win_c ? '{we: we1, addr: addr1, wdata: wdata1}
                                    : '{we: we0, addr: addr0, wdata: wdata0};
                end
            end
            SETUP:   state_d = STROBE;
            STROBE:  state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, latched transaction and registered RAM/port outputs.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q  <= IDLE;
            txn_q    <= '0;
            grant_q  <= 1'b0;
            drive_q  <= 1'b0;
            ce_b_q   <= STROBE_OFF;
            we_b_q   <= STROBE_OFF;
            oe_b_q   <= STROBE_OFF;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            txn_q   <= txn_d;
            grant_q <= grant_d;
            drive_q <= (state_d != IDLE) && txn_d.we;
            ce_b_q  <= (state_d == STROBE) ? ~STROBE_OFF : STROBE_OFF;
            we_b_q  <= ((state_d == STROBE) && txn_d.we) ? ~STROBE_OFF : STROBE_OFF;
            oe_b_q  <= ((state_d == STROBE) && !txn_d.we) ? ~STROBE_OFF : STROBE_OFF;
            ack0_q  <= (state_d == HOLD) && !grant_d;
            ack1_q  <= (state_d == HOLD) && grant_d;
            // Read data is captured while OEb is still low, at the STROBE->HOLD edge.
            if ((state_q == STROBE) && !txn_q.we) begin
                if (grant_q) begin
                    rdata1_q <= ram_data;
                end else begin
                    rdata0_q <= ram_data;
                end
            end
        end
    end

    assign ram_data = drive_q ? txn_q.wdata : {DATA_W{1'bz}};
    assign ram_addr = txn_q.addr;
    assign ram_CEb  = ce_b_q;
    assign ram_WEb  = we_b_q;
    assign ram_OEb  = oe_b_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Self-checking bench for ram_bus_arbiter with a behavioural 16x8 RAM and a scoreboard.
// Expected grant order follows RAM_ARB_ROUND_ROBIN_EN.
module tb_ram_bus_arbiter;

    logic       clk  = 1'b0;
    logic       rstb = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [3:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    wire        ack0, ack1;
    wire  [7:0] rdata0, rdata1;
    wire  [3:0] ram_addr;
    wire  [7:0] ram_data;
    wire        ram_CEb, ram_WEb, ram_OEb;

    logic [7:0] mem     [16];
    logic [7:0] ref_mem [16];

    typedef struct packed {
        logic       port;
        logic       we;
        logic [3:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t sb_q[$];
    bit   sb_en = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   ce_cnt = 0;
    int   wr_cnt = 0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;

    ram_bus_arbiter dut (
        .clk(clk), .rstb(rstb),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_CEb(ram_CEb), .ram_WEb(ram_WEb), .ram_OEb(ram_OEb)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: drives the bus on a read strobe, stores the word during a write strobe.
    assign ram_data = (!ram_CEb && !ram_OEb) ? mem[ram_addr] : 8'bz;
    always @(posedge clk) if (!ram_CEb && !ram_WEb) mem[ram_addr] <= ram_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Invariants every cycle, plus scoreboard compare on each ack.
    always @(negedge clk) begin
        exp_t e;
        chk("inv_we_oe", 32'(ram_WEb | ram_OEb), 32'd1);
        chk("inv_ce", 32'(ram_CEb), 32'(ram_WEb & ram_OEb));
        if (!ram_OEb) chk("rd_bus", 32'(ram_data), 32'(mem[ram_addr]));
        if (!ram_CEb) begin
            ce_cnt++;
            if (!ram_WEb) begin
                wr_cnt++;
                wr_addr = ram_addr;
                wr_data = ram_data;
            end
        end
        if (ack0 || ack1) begin
            if (sb_en) begin
                chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("ack_port", 32'({ack1, ack0}), e.port ? 32'd2 : 32'd1);
                    chk("strobe_cnt", 32'(ce_cnt), 32'd1);
                    if (e.we) begin
                        chk("wr_cnt", 32'(wr_cnt), 32'd1);
                        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                        chk("wr_data", 32'(wr_data), 32'(e.data));
                    end else begin
                        chk("wr_cnt_rd", 32'(wr_cnt), 32'd0);
                        chk("rdata", e.port ? 32'(rdata1) : 32'(rdata0), 32'(e.data));
                    end
                end
            end
            ce_cnt = 0;
            wr_cnt = 0;
        end
        if (!rstb) begin
            ce_cnt = 0;
            wr_cnt = 0;
        end
    end

    function automatic exp_t mk_exp(input bit p, input bit w, input logic [3:0] a, input logic [7:0] d);
        exp_t e;
        e.port = p;
        e.we   = w;
        e.addr = a;
        e.data = w ? d : ref_mem[a];
        return e;
    endfunction

    task automatic drive(input bit p, input bit w, input logic [3:0] a, input logic [7:0] d);
        if (p) begin
            req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    task automatic drop(input bit p, input bit scramble);
        if (p) begin
            req1 = 1'b0;
            if (scramble) begin addr1 = ~addr1; wdata1 = ~wdata1; end
        end else begin
            req0 = 1'b0;
            if (scramble) begin addr0 = ~addr0; wdata0 = ~wdata0; end
        end
    endtask

    // One transaction from an idle bus, checking every phase; starts and ends at a negedge.
    task automatic txn(input bit p, input bit w, input logic [3:0] a, input logic [7:0] d, input bit scramble);
        sb_q.push_back(mk_exp(p, w, a, d));
        if (w) ref_mem[a] = d;
        drive(p, w, a, d);
        @(posedge clk);
        @(negedge clk);
        drop(p, scramble);
        chk("setup_strb", 32'({ram_CEb, ram_WEb, ram_OEb}), 32'b111);
        chk("setup_addr", 32'(ram_addr), 32'(a));
        chk("setup_ack", 32'({ack1, ack0}), 32'd0);
        @(negedge clk);
        chk("strobe_strb", 32'({ram_CEb, ram_WEb, ram_OEb}), w ? 32'b001 : 32'b010);
        chk("strobe_ack", 32'({ack1, ack0}), 32'd0);
        @(negedge clk);
        chk("hold_strb", 32'({ram_CEb, ram_WEb, ram_OEb}), 32'b111);
        chk("hold_ack", 32'({ack1, ack0}), p ? 32'd2 : 32'd1);
        @(negedge clk);
        chk("idle_ack", 32'({ack1, ack0}), 32'd0);
    endtask

    initial begin
        int n0, n1;
        bit rr;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 8'hFF;
            ref_mem[i] = 8'hFF;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_strb", 32'({ram_CEb, ram_WEb, ram_OEb}), 32'b111);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_ack", 32'({ack1, ack0}), 32'd0);
        chk("rst_rdata", 32'({rdata1, rdata0}), 32'd0);
        rstb = 1'b1;
        @(negedge clk);

        // Reset contents, then write on port 0
        txn(1'b1, 1'b0, 4'hF, 8'h00, 1'b0);
        txn(1'b0, 1'b1, 4'h3, 8'hA5, 1'b0);

        // Reset asserted during the STROBE of a read: no ack, no rdata update
        drive(1'b0, 1'b0, 4'h3, 8'h00);
        @(posedge clk);
        @(negedge clk);
        drop(1'b0, 1'b0);
        @(negedge clk);
        chk("rmid_strobe", 32'({ram_CEb, ram_WEb, ram_OEb}), 32'b010);
        rstb = 1'b0;
        @(negedge clk);
        chk("rmid_strb", 32'({ram_CEb, ram_WEb, ram_OEb}), 32'b111);
        chk("rmid_ack", 32'({ack1, ack0}), 32'd0);
        chk("rmid_rdata0", 32'(rdata0), 32'd0);
        rstb = 1'b1;
        @(negedge clk);
        chk("rmid_ack2", 32'({ack1, ack0}), 32'd0);
        @(negedge clk);

        // Clean read after release, then fields altered during SETUP
        txn(1'b0, 1'b0, 4'h3, 8'h00, 1'b0);
        txn(1'b0, 1'b1, 4'h7, 8'h3C, 1'b1);
        txn(1'b0, 1'b0, 4'h7, 8'h00, 1'b0);
        txn(1'b0, 1'b0, 4'h8, 8'h00, 1'b0);
        txn(1'b1, 1'b0, 4'hF, 8'h00, 1'b0);

        // Simultaneous requests, three transactions per port
        for (int k = 0; k < 6; k++) begin
            bit p;
            p = rr ? k[0] : (k >= 3);
            sb_q.push_back(mk_exp(p, 1'b0, p ? 4'h7 : 4'h3, 8'h00));
        end
        drive(1'b0, 1'b0, 4'h3, 8'h00);
        drive(1'b1, 1'b0, 4'h7, 8'h00);
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 60 && (n0 < 3 || n1 < 3); c++) begin
            @(negedge clk);
            if (ack0) begin n0++; if (n0 == 3) req0 = 1'b0; end
            if (ack1) begin n1++; if (n1 == 3) req1 = 1'b0; end
        end
        chk("simul_n0", 32'(n0), 32'd3);
        chk("simul_n1", 32'(n1), 32'd3);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        // Random traffic for the bus invariants
        sb_en = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            req0 = 1'($urandom_range(0, 1));
            req1 = 1'($urandom_range(0, 1));
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            addr0 = 4'($urandom);
            addr1 = 4'($urandom);
            wdata0 = 8'($urandom);
            wdata1 = 8'($urandom);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (6) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
